// File: rtl/calcu16_pkg.sv
// Shared calcu16 definitions: loader state encoding, error codes, opcodes and default widths.
package calcu16_pkg;

    localparam int unsigned CALCU16_ADDR_W         = 16;
    localparam int unsigned CALCU16_WORD_W         = 26;
    localparam int unsigned CALCU16_BYTES_PER_WORD = (CALCU16_WORD_W + 7) / 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } loader_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_PAD  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    // Opcode field values shared with the core decoder
    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_LDI  = 5'h08;
    localparam logic [4:0] OP_JMP  = 5'h10;
    localparam logic [4:0] OP_HALT = 5'h1f;

endpackage

// File: rtl/calcu16_loader_asm.sv
// Byte-to-word assembler: collects four MSB-first bytes and flags nonzero bits above WORD_W.
module calcu16_loader_asm
    import calcu16_pkg::*;
#(
    parameter int unsigned WORD_W = CALCU16_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [7:0]        in_byte,
    output logic              word_valid_c,
    output logic              pad_err_c,
    output logic [WORD_W-1:0] word_c
);

    logic [1:0]  byte_idx;
    logic [23:0] sr;
    logic [31:0] full;

    // The fourth byte is used as it arrives so the FSM can decide on the same edge
    assign full         = {sr, in_byte};
    assign word_c       = full[WORD_W-1:0];
    assign word_valid_c = shift_en && (byte_idx == 2'd3);
    assign pad_err_c    = (full >> WORD_W) != 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
            sr       <= 24'd0;
        end else if (clr) begin
            byte_idx <= 2'd0;
            sr       <= 24'd0;
        end else if (shift_en) begin
            byte_idx <= byte_idx + 2'd1;
            sr       <= {sr[15:0], in_byte};
        end
    end

endmodule

// File: rtl/calcu16_loader.sv
// Runtime program loader for the calcu16 instruction memory; holds the core while loading.
// Optional trailing XOR checksum byte enabled by defining CALCU16_LOADER_CHECKSUM_EN.
module calcu16_loader
    import calcu16_pkg::*;
#(
    parameter int unsigned ADDR_W = CALCU16_ADDR_W,
    parameter int unsigned WORD_W = CALCU16_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    loader_state_t     state, state_nxt, fin_state;
    logic [ADDR_W-1:0] addr, addr_inc, count, hdr_count;
    logic [7:0]        cnt_hi;
    logic              xfer, start_ok, shift_en, csum_ok;
    logic              word_valid_c, pad_err_c;
    logic [WORD_W-1:0] word_c;

    assign xfer      = in_valid && in_ready;
    assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign shift_en  = xfer && (state == ST_DATA);
    assign addr_inc  = addr + ADDR_W'(1);
    assign hdr_count = ADDR_W'({cnt_hi, in_data});

`ifdef CALCU16_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    assign fin_state = ST_CSUM;
    assign csum_ok   = (in_data == csum);

    // Running XOR over header and data bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'd0;
        end else if (start_ok) begin
            csum <= 8'd0;
        end else if (xfer && (state == ST_HDR_HI || state == ST_HDR_LO || state == ST_DATA)) begin
            csum <= csum ^ in_data;
        end
    end
`else
    assign fin_state = ST_DONE;
    assign csum_ok   = 1'b0;
`endif

    calcu16_loader_asm #(.WORD_W(WORD_W)) u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (start_ok),
        .shift_en     (shift_en),
        .in_byte      (in_data),
        .word_valid_c (word_valid_c),
        .pad_err_c    (pad_err_c),
        .word_c       (word_c)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_HDR_HI;
            ST_HDR_HI: if (xfer) state_nxt = ST_HDR_LO;
            ST_HDR_LO: if (xfer) state_nxt = (hdr_count == '0) ? fin_state : ST_DATA;
            ST_DATA:   if (word_valid_c) state_nxt = pad_err_c ? ST_ERR : ST_WRITE;
            ST_WRITE:  state_nxt = (addr_inc == count) ? fin_state : ST_DATA;
`ifdef CALCU16_LOADER_CHECKSUM_EN
            ST_CSUM:   if (xfer) state_nxt = csum_ok ? ST_DONE : ST_ERR;
`endif
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_hold <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            addr      <= '0;
            count     <= '0;
            cnt_hi    <= 8'd0;
        end else begin
            state     <= state_nxt;
            in_ready  <= state_nxt inside {ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CSUM};
            core_hold <= state_nxt inside {ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_WRITE, ST_CSUM};
            mem_we    <= (state_nxt == ST_WRITE);
            if (start_ok) begin
                done     <= 1'b0;
                err      <= 1'b0;
                err_code <= ERR_NONE;
                addr     <= '0;
            end
            if (xfer && state == ST_HDR_HI) cnt_hi <= in_data;
            if (xfer && state == ST_HDR_LO) count <= hdr_count;
            if (state == ST_DATA && state_nxt == ST_WRITE) begin
                mem_addr  <= addr;
                mem_wdata <= word_c;
            end
            if (state == ST_WRITE) addr <= addr_inc;
            if (state != ST_DONE && state_nxt == ST_DONE) done <= 1'b1;
            if (state != ST_ERR && state_nxt == ST_ERR) begin
                err      <= 1'b1;
                err_code <= (state == ST_DATA) ? ERR_PAD : ERR_CSUM;
            end
        end
    end

endmodule

// File: tb/tb_calcu16_loader.sv
// Scoreboard bench for calcu16_loader: expected memory writes are queued, a monitor checks each mem_we.
module tb_calcu16_loader;

    typedef struct packed {
        logic [15:0] addr;
        logic [25:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, core_hold, done, err;
    logic [15:0] mem_addr;
    logic [25:0] mem_wdata;
    logic [1:0]  err_code;

    wr_t        exp_q[$];
    logic [7:0] stim[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    calcu16_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_hold (core_hold),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mem_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                        errors++;
                        $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                                 mem_addr, mem_wdata, e.addr, e.data);
                    end
                end
                check("in_ready_in_write", 32'(in_ready), 32'd0);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready 0 after %0d cycles expected 1", n);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
    endtask

    task automatic send_stim(input bit toggle);
        foreach (stim[i]) begin
            send_byte(stim[i]);
            if (toggle) begin
                in_valid = 1'b0;
                in_data  = 8'hA5;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    function automatic void add_csum();
`ifdef CALCU16_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
        foreach (stim[i]) x = x ^ stim[i];
        stim.push_back(x);
`endif
    endfunction

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1 && err !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got done 0 err 0 expected completion", name);
        end
    endtask

    task automatic load_two_words(input bit toggle);
        stim = '{8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h05, 8'h02, 8'h04, 8'h00, 8'h03};
        add_csum();
        exp_q.push_back('{addr: 16'h0000, data: 26'h1000005});
        exp_q.push_back('{addr: 16'h0001, data: 26'h2040003});
        pulse_start();
        check("hold_after_start", 32'(core_hold), 32'd1);
        send_stim(toggle);
        wait_end("two_words");
        check("two_done", 32'(done), 32'd1);
        check("two_err", 32'(err), 32'd0);
        check("two_hold", 32'(core_hold), 32'd0);
        check("two_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_core_hold"}, 32'(core_hold), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Two words, continuous valid, then with valid toggling
        load_two_words(1'b0);
        load_two_words(1'b1);

        // Pad bit set: abort before any write, last write data held
        stim = '{8'h00, 8'h01, 8'h40, 8'h00, 8'h00, 8'h00};
        pulse_start();
        send_stim(1'b0);
        wait_end("pad");
        check("pad_err", 32'(err), 32'd1);
        check("pad_err_code", 32'(err_code), 32'd1);
        check("pad_done", 32'(done), 32'd0);
        check("pad_hold", 32'(core_hold), 32'd0);
        check("pad_addr_held", 32'(mem_addr), 32'd1);
        check("pad_wdata_held", 32'(mem_wdata), 32'h2040003);

`ifdef CALCU16_LOADER_CHECKSUM_EN
        // Bad trailing checksum: word stays written, then abort
        stim = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};
        exp_q.push_back('{addr: 16'h0000, data: 26'h0000001});
        pulse_start();
        send_stim(1'b0);
        wait_end("csum");
        check("csum_err", 32'(err), 32'd1);
        check("csum_err_code", 32'(err_code), 32'd2);
        check("csum_hold", 32'(core_hold), 32'd0);
        check("csum_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

        // Reset in the middle of the first word, then a clean reload
        stim = '{8'h00, 8'h02, 8'h01, 8'h00};
        pulse_start();
        send_stim(1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_two_words(1'b0);

        // start pulsed mid-word is ignored; all-ones 26-bit word is legal
        stim = '{8'h00, 8'h01, 8'h03, 8'hFF};
        exp_q.push_back('{addr: 16'h0000, data: 26'h3FFFFFF});
        pulse_start();
        send_stim(1'b0);
        pulse_start();
        check("busy_start_hold", 32'(core_hold), 32'd1);
        check("busy_start_ready", 32'(in_ready), 32'd1);
        stim = '{8'hFF, 8'hFF};
`ifdef CALCU16_LOADER_CHECKSUM_EN
        stim.push_back(8'h00 ^ 8'h01 ^ 8'h03 ^ 8'hFF ^ 8'hFF ^ 8'hFF);
`endif
        send_stim(1'b0);
        wait_end("busy_start");
        check("busy_start_done", 32'(done), 32'd1);
        check("busy_start_err", 32'(err), 32'd0);
        check("busy_start_sb_empty", 32'(exp_q.size()), 32'd0);

        // Zero-length program completes with no write
        stim = '{8'h00, 8'h00};
        add_csum();
        pulse_start();
        send_stim(1'b0);
        wait_end("zero");
        repeat (3) @(negedge clk);
        check("zero_done", 32'(done), 32'd1);
        check("zero_err", 32'(err), 32'd0);
        check("zero_hold", 32'(core_hold), 32'd0);
        check("zero_we", 32'(mem_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
